pwm_load_scheduler: RTL and testbench

Arbitrates duty/phase load requests from up to N_CH requesters onto the shared 12-bit Load bus of N_CH triangle-counter PWM channels, and generates each channel's Load_en pulse. Each channel's PWM counter resynchronises on its own Load_en pulse. Because Load is common to all channels, only one transfer may be in flight at a time. The block sits between the control logic (setpoint/phase sources) and the PWM channel array.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_rr_arbiter.sv | 31 +++
 rtl/pwm_load_scheduler.sv | 124 ++++++++++++
 tb/tb_pwm_load_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM constants, scheduler state encoding and load clamp helpers.
package pwm_pkg;

  localparam int unsigned CNT_W      = 12;
  localparam int unsigned PERIOD_MAX = 999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2
  } sched_state_e;

  // True when a requested load exceeds the highest legal counter value.
  function automatic logic over_max(input logic [CNT_W-1:0] value);
    return value > CNT_W'(PERIOD_MAX);
  endfunction

  // Saturate a requested load to the legal counter range.
  function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] value);
    return over_max(value) ? CNT_W'(PERIOD_MAX) : value;
  endfunction

endpackage

// File: rtl/pwm_rr_arbiter.sv
// Combinational round-robin arbiter; search starts just after the last grant.
module pwm_rr_arbiter #(
  parameter int unsigned N  = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk the requesters from last+1 around to last, taking the first one set.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PW'((32'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/pwm_load_scheduler.sv
// Serialises duty/phase loads from N_CH requesters onto the shared Load bus.
module pwm_load_scheduler
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned EN_HOLD = 3,
  parameter int unsigned GAP     = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [N_CH-1:0]       Req,
  input  logic [N_CH*CNT_W-1:0] Req_value,
  output logic [N_CH-1:0]       Ack,
  output logic [CNT_W-1:0]      Load,
  output logic [N_CH-1:0]       Load_en,
  output logic                  Busy,
  output logic                  Clamped
);

  localparam int unsigned PW       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned HOLD_MAX = (EN_HOLD > GAP) ? EN_HOLD : GAP;
  localparam int unsigned HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

  sched_state_e      state, state_n;
  logic [HW-1:0]     cnt, cnt_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [N_CH-1:0]   grant;
  logic              grant_valid;
  logic [CNT_W-1:0]  sel_value;
  logic [PW-1:0]     gidx;
  logic [N_CH-1:0]   ack_n;
  logic [N_CH-1:0]   load_en_n;
  logic [CNT_W-1:0]  load_n;
  logic              clamped_n;
  logic              busy_n;

  pwm_rr_arbiter #(.N(N_CH)) u_arb (
    .req   (Req),
    .last  (ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  // Pick the granted requester's value and index from the one-hot grant.
  always_comb begin
    sel_value = '0;
    gidx      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        sel_value = Req_value[i*CNT_W +: CNT_W];
        gidx      = PW'(i);
      end
    end
  end

  // Next-state and next-output logic for the grant/drive/settle sequence.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    ack_n     = '0;
    load_n    = Load;
    load_en_n = Load_en;
    clamped_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          ack_n     = grant;
          load_en_n = grant;
          load_n    = clamp_load(sel_value);
          clamped_n = over_max(sel_value);
          ptr_n     = gidx;
          cnt_n     = HW'(EN_HOLD - 1);
          state_n   = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          load_en_n = '0;
          cnt_n     = HW'(GAP - 1);
          state_n   = SETTLE;
        end else begin
          cnt_n = cnt - HW'(1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - HW'(1);
        end
      end
      default: begin
        load_en_n = '0;
        state_n   = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, pointer and registered outputs; reset abandons any transfer.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= PW'(N_CH - 1);
      Ack     <= '0;
      Load    <= '0;
      Load_en <= '0;
      Busy    <= 1'b0;
      Clamped <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
      Ack     <= ack_n;
      Load    <= load_n;
      Load_en <= load_en_n;
      Busy    <= busy_n;
      Clamped <= clamped_n;
    end
  end

endmodule

// File: tb/tb_pwm_load_scheduler.sv
// Scoreboard bench for pwm_load_scheduler: directed requests, monitor on Ack.
module tb_pwm_load_scheduler;

  localparam int N  = 3;
  localparam int CW = 12;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic [N-1:0]    Req = '0;
  logic [N*CW-1:0] Req_value = '0;
  logic [N-1:0]    Ack;
  logic [CW-1:0]   Load;
  logic [N-1:0]    Load_en;
  logic            Busy;
  logic            Clamped;

  typedef struct {
    logic [N-1:0]  ack;
    logic [CW-1:0] load;
    logic          clamped;
    int            edge_no;
  } exp_t;

  exp_t sb[$];
  int   edge_n      = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   busy_run    = 0;
  int   en_run      = 0;
  bit   skip_b      = 0;
  bit   skip_e      = 0;
  bit   prev_busy   = 0;
  logic [CW-1:0] prev_load = '0;
  bit   en0_late    = 0;

  pwm_load_scheduler dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req       (Req),
    .Req_value (Req_value),
    .Ack       (Ack),
    .Load      (Load),
    .Load_en   (Load_en),
    .Busy      (Busy),
    .Clamped   (Clamped)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Advance to just after the given rising edge.
  task automatic at(input int e);
    while (edge_n < e) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic expect_grant(input logic [N-1:0] ack, input int load, input logic clamped,
                              input int e);
    exp_t x;
    x.ack = ack; x.load = CW'(load); x.clamped = clamped; x.edge_no = e;
    sb.push_back(x);
  endtask

  task automatic set_val(input int ch, input int v);
    Req_value[ch*CW +: CW] = CW'(v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},     32'(Ack),     0);
    check({tag, "_load"},    32'(Load),    0);
    check({tag, "_load_en"}, 32'(Load_en), 0);
    check({tag, "_busy"},    32'(Busy),    0);
    check({tag, "_clamped"}, 32'(Clamped), 0);
  endtask

  // Monitor: scoreboard on Ack, plus pulse-length, one-hot and Load-stability checks.
  always @(negedge Clock) begin
    if (Ack != '0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: got ack=%b load=%0d expected no grant (edge %0d)",
                 Ack, Load, edge_n);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("ack",       32'(Ack),     32'(x.ack));
        check("load",      32'(Load),    32'(x.load));
        check("clamped",   32'(Clamped), 32'(x.clamped));
        check("ack_en",    32'(Load_en), 32'(x.ack));
        check("ack_edge",  32'(edge_n),  32'(x.edge_no));
      end
    end else if (Clamped) begin
      check("clamp_without_ack", 32'(Clamped), 0);
    end
    check("load_en_onehot", 32'($countones(Load_en) <= 1), 1);
    if (Busy && prev_busy) check("load_stable", 32'(Load), 32'(prev_load));

    if (Busy) busy_run++;
    else begin
      if (busy_run != 0) begin
        if (!skip_b) check("busy_len", 32'(busy_run), 6);
        skip_b = 0;
      end
      busy_run = 0;
    end
    if (Load_en != '0) en_run++;
    else begin
      if (en_run != 0) begin
        if (!skip_e) check("load_en_len", 32'(en_run), 3);
        skip_e = 0;
      end
      en_run = 0;
    end
    if (Reset) begin
      if (busy_run != 0) skip_b = 1;
      if (en_run != 0) skip_e = 1;
    end
    if (Load_en[0] && edge_n >= 99) en0_late = 1;
    prev_busy = Busy;
    prev_load = Load;
  end

  initial begin
    // Reset state
    at(2);
    check_all_zero("reset");
    Reset = 1'b0;

    // Single request held over two grants: Ack at 3, next grant 7 edges later
    Req = 3'b001; set_val(0, 250);
    expect_grant(3'b001, 250, 1'b0, 3);
    expect_grant(3'b001, 250, 1'b0, 10);
    at(10); Req = '0;

    // Round-robin with all requesting after a fresh reset: 0,1,2,0
    at(16); Reset = 1'b1;
    at(17); Reset = 1'b0;
    Req = 3'b111; set_val(0, 100); set_val(1, 200); set_val(2, 300);
    expect_grant(3'b001, 100, 1'b0, 18);
    expect_grant(3'b010, 200, 1'b0, 25);
    expect_grant(3'b100, 300, 1'b0, 32);
    expect_grant(3'b001, 100, 1'b0, 39);
    at(39); Req = '0;

    // Clamp: 4000 -> 999 with Clamped; then exactly 999 is not clamped
    at(45); Req = 3'b010; set_val(1, 4000);
    expect_grant(3'b010, 999, 1'b1, 46);
    at(46); set_val(1, 999);
    expect_grant(3'b010, 999, 1'b0, 53);
    at(53); Req = '0;

    // Request during Busy waits; value changes after Ack are ignored
    at(59); Req = 3'b001; set_val(0, 500);
    expect_grant(3'b001, 500, 1'b0, 60);
    at(60); Req = '0;
    at(61); Req = 3'b100; set_val(2, 700);
    expect_grant(3'b100, 700, 1'b0, 67);
    at(67); Req = 3'b010; set_val(1, 123);
    expect_grant(3'b010, 123, 1'b0, 74);
    at(74); Req = '0; set_val(1, 456);
    at(76); check("load_after_ack_change", 32'(Load), 123);

    // Reset mid-DRIVE, then pointer restarts so requester 1 wins over 2
    at(80); Req = 3'b001; set_val(0, 77);
    expect_grant(3'b001, 77, 1'b0, 81);
    at(81); Req = '0;
    at(82); Reset = 1'b1; Req = 3'b110; set_val(1, 11); set_val(2, 22);
    at(83); check_all_zero("mid_reset");
    Reset = 1'b0;
    expect_grant(3'b010, 11, 1'b0, 84);
    at(84); Req = 3'b100;
    expect_grant(3'b100, 22, 1'b0, 91);
    at(91); Req = '0;

    // Withdrawal: one-cycle Req[0] pulse while Busy is never granted
    at(97); Req = 3'b010; set_val(1, 5); set_val(0, 900);
    expect_grant(3'b010, 5, 1'b0, 98);
    at(98); Req = '0;
    at(99); Req = 3'b001;
    at(100); Req = '0;

    at(115);
    check("withdraw_no_load_en0", 32'(en0_late), 0);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
